// File: rtl/ram_arbiter_pkg.sv
// Shared encodings for the data-RAM arbiter: FSM states, owner IDs and the
// burst-counter width helper.
package ram_arbiter_pkg;

  localparam int ARB_STATE_WIDTH = 2;

  typedef enum logic [ARB_STATE_WIDTH-1:0] {
    ARB_STATE_IDLE    = 2'd0,
    ARB_STATE_OWN_CPU = 2'd1,
    ARB_STATE_OWN_DMA = 2'd2
  } arb_state_e;

  typedef enum logic {
    ARB_OWNER_CPU = 1'b0,
    ARB_OWNER_DMA = 1'b1
  } arb_owner_e;

  // Counter must hold values 0..max_burst inclusive.
  function automatic int burst_cnt_width(input int max_burst);
    return $clog2(max_burst + 1);
  endfunction

endpackage

// File: rtl/ram_arbiter.sv
// Round-robin arbiter sharing the single-port data RAM between the CPU
// datapath and the DMA/debug loader. An owner may keep the RAM for up to
// MAX_BURST consecutive grants while the other side waits; hand-over happens
// in the same cycle, so there is never a dead cycle under contention.
//
//   state      | meaning
//   -----------+------------------------------------------------------
//   IDLE       | nobody granted last cycle; ties go to != last_owner
//   OWN_CPU    | CPU granted last cycle; cnt = its consecutive grants
//   OWN_DMA    | DMA granted last cycle; cnt = its consecutive grants
module ram_arbiter
  import ram_arbiter_pkg::*;
#(
  parameter int ADDR_WIDTH = 11,
  parameter int DATA_WIDTH = 16,
  parameter int MAX_BURST  = 4
) (
  input  logic                  clk,
  input  logic                  rst,

  input  logic                  cpu_req,
  input  logic                  cpu_we,
  input  logic [ADDR_WIDTH-1:0] cpu_addr,
  input  logic [DATA_WIDTH-1:0] cpu_wdata,
  output logic                  cpu_gnt,
  output logic                  cpu_stall,
  output logic                  cpu_rvalid,
  output logic [DATA_WIDTH-1:0] cpu_rdata,

  input  logic                  dma_req,
  input  logic                  dma_we,
  input  logic [ADDR_WIDTH-1:0] dma_addr,
  input  logic [DATA_WIDTH-1:0] dma_wdata,
  output logic                  dma_gnt,
  output logic                  dma_rvalid,
  output logic [DATA_WIDTH-1:0] dma_rdata,

  output logic [ADDR_WIDTH-1:0] ram_addr,
  output logic [DATA_WIDTH-1:0] ram_wdata,
  output logic                  ram_write,
  input  logic [DATA_WIDTH-1:0] ram_rdata
);

  localparam int               CNT_W   = burst_cnt_width(MAX_BURST);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_BURST);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  arb_state_e       state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  arb_owner_e       last_owner, last_owner_nxt;
  logic             cpu_keep, dma_keep;

  // The burst limit only matters while the other requester is waiting.
  assign cpu_keep = cpu_req & ((cnt < CNT_MAX) | ~dma_req);
  assign dma_keep = dma_req & ((cnt < CNT_MAX) | ~cpu_req);

  // Grant selection and next-state; grants are suppressed while in reset.
  always_comb begin
    state_nxt      = state;
    cnt_nxt        = cnt;
    last_owner_nxt = last_owner;
    cpu_gnt        = 1'b0;
    dma_gnt        = 1'b0;

    case (state)
      ARB_STATE_IDLE: begin
        if (cpu_req && (!dma_req || last_owner == ARB_OWNER_DMA)) cpu_gnt = 1'b1;
        else if (dma_req)                                         dma_gnt = 1'b1;
      end
      ARB_STATE_OWN_CPU: begin
        if (cpu_keep)     cpu_gnt = 1'b1;
        else if (dma_req) dma_gnt = 1'b1;
      end
      ARB_STATE_OWN_DMA: begin
        if (dma_keep)     dma_gnt = 1'b1;
        else if (cpu_req) cpu_gnt = 1'b1;
      end
      default: ;
    endcase

    if (rst) begin
      cpu_gnt = 1'b0;
      dma_gnt = 1'b0;
    end

    if (cpu_gnt) begin
      state_nxt      = ARB_STATE_OWN_CPU;
      last_owner_nxt = ARB_OWNER_CPU;
      if (state == ARB_STATE_OWN_CPU) cnt_nxt = (cnt < CNT_MAX) ? cnt + CNT_ONE : cnt;
      else                            cnt_nxt = CNT_ONE;
    end else if (dma_gnt) begin
      state_nxt      = ARB_STATE_OWN_DMA;
      last_owner_nxt = ARB_OWNER_DMA;
      if (state == ARB_STATE_OWN_DMA) cnt_nxt = (cnt < CNT_MAX) ? cnt + CNT_ONE : cnt;
      else                            cnt_nxt = CNT_ONE;
    end else begin
      state_nxt = ARB_STATE_IDLE;
      cnt_nxt   = '0;
    end
  end

  // State register plus the one-cycle read-valid pipeline.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ARB_STATE_IDLE;
      cnt        <= '0;
      last_owner <= ARB_OWNER_DMA;
      cpu_rvalid <= 1'b0;
      dma_rvalid <= 1'b0;
    end else begin
      state      <= state_nxt;
      cnt        <= cnt_nxt;
      last_owner <= last_owner_nxt;
      cpu_rvalid <= cpu_req & cpu_gnt & ~cpu_we;
      dma_rvalid <= dma_req & dma_gnt & ~dma_we;
    end
  end

  // RAM port mux; parks at zero whenever nobody holds a grant.
  always_comb begin
    ram_addr  = '0;
    ram_wdata = '0;
    ram_write = 1'b0;
    if (cpu_gnt) begin
      ram_addr  = cpu_addr;
      ram_wdata = cpu_wdata;
      ram_write = cpu_we;
    end else if (dma_gnt) begin
      ram_addr  = dma_addr;
      ram_wdata = dma_wdata;
      ram_write = dma_we;
    end
  end

  assign cpu_stall = cpu_req & ~cpu_gnt;
  assign cpu_rdata = ram_rdata;
  assign dma_rdata = ram_rdata;

endmodule

// File: tb/tb_ram_arbiter.sv
// Bench for ram_arbiter: two instances (MAX_BURST=4 and MAX_BURST=1), each with
// its own RAM macro and a behavioural arbitration model checked every cycle,
// plus directed scenarios with literal expectations.
module tb_ram_arbiter;

  localparam int AW = 11;
  localparam int DW = 16;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic          a_cpu_req, a_cpu_we, a_cpu_gnt, a_cpu_stall, a_cpu_rvalid;
  logic [AW-1:0] a_cpu_addr;
  logic [DW-1:0] a_cpu_wdata, a_cpu_rdata;
  logic          a_dma_req, a_dma_we, a_dma_gnt, a_dma_rvalid;
  logic [AW-1:0] a_dma_addr;
  logic [DW-1:0] a_dma_wdata, a_dma_rdata;
  logic [AW-1:0] a_ram_addr;
  logic [DW-1:0] a_ram_wdata, a_ram_rdata;
  logic          a_ram_write;

  logic          b_cpu_req, b_cpu_we, b_cpu_gnt, b_cpu_stall, b_cpu_rvalid;
  logic [AW-1:0] b_cpu_addr;
  logic [DW-1:0] b_cpu_wdata, b_cpu_rdata;
  logic          b_dma_req, b_dma_we, b_dma_gnt, b_dma_rvalid;
  logic [AW-1:0] b_dma_addr;
  logic [DW-1:0] b_dma_wdata, b_dma_rdata;
  logic [AW-1:0] b_ram_addr;
  logic [DW-1:0] b_ram_wdata, b_ram_rdata;
  logic          b_ram_write;

  ram_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .MAX_BURST(4)) u_dut_a (
    .clk(clk), .rst(rst),
    .cpu_req(a_cpu_req), .cpu_we(a_cpu_we), .cpu_addr(a_cpu_addr), .cpu_wdata(a_cpu_wdata),
    .cpu_gnt(a_cpu_gnt), .cpu_stall(a_cpu_stall), .cpu_rvalid(a_cpu_rvalid), .cpu_rdata(a_cpu_rdata),
    .dma_req(a_dma_req), .dma_we(a_dma_we), .dma_addr(a_dma_addr), .dma_wdata(a_dma_wdata),
    .dma_gnt(a_dma_gnt), .dma_rvalid(a_dma_rvalid), .dma_rdata(a_dma_rdata),
    .ram_addr(a_ram_addr), .ram_wdata(a_ram_wdata), .ram_write(a_ram_write), .ram_rdata(a_ram_rdata)
  );

  ram_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .MAX_BURST(1)) u_dut_b (
    .clk(clk), .rst(rst),
    .cpu_req(b_cpu_req), .cpu_we(b_cpu_we), .cpu_addr(b_cpu_addr), .cpu_wdata(b_cpu_wdata),
    .cpu_gnt(b_cpu_gnt), .cpu_stall(b_cpu_stall), .cpu_rvalid(b_cpu_rvalid), .cpu_rdata(b_cpu_rdata),
    .dma_req(b_dma_req), .dma_we(b_dma_we), .dma_addr(b_dma_addr), .dma_wdata(b_dma_wdata),
    .dma_gnt(b_dma_gnt), .dma_rvalid(b_dma_rvalid), .dma_rdata(b_dma_rdata),
    .ram_addr(b_ram_addr), .ram_wdata(b_ram_wdata), .ram_write(b_ram_write), .ram_rdata(b_ram_rdata)
  );

  // RAM macros: read data appears one cycle after the address.
  logic [DW-1:0] mem    [2][2048];
  logic [DW-1:0] shadow [2][2048];

  always @(posedge clk) begin
    if (a_ram_write) mem[0][a_ram_addr] <= a_ram_wdata;
    a_ram_rdata <= mem[0][a_ram_addr];
    if (b_ram_write) mem[1][b_ram_addr] <= b_ram_wdata;
    b_ram_rdata <= mem[1][b_ram_addr];
  end

  // Model: who was granted last cycle (0 none, 1 cpu, 2 dma), how many
  // grants in a row it has had, and the last winner for tie-breaking.
  typedef struct {
    int            busy;
    int            streak;
    int            last_win;
    logic          exp_crv;
    logic          exp_drv;
    logic [DW-1:0] exp_rd;
  } model_t;

  model_t m [2];
  int     n_vec = 0;
  int     n_err = 0;
  bit     chk_on = 1'b0;
  int     rec_id = -1;
  int     hd[$];
  int     hm[$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", nm, act, exp);
    end
  endtask

  task automatic step(input int id, input int max_b,
                      input logic creq, input logic cwe, input logic [AW-1:0] caddr, input logic [DW-1:0] cwd,
                      input logic dreq, input logic dwe, input logic [AW-1:0] daddr, input logic [DW-1:0] dwd,
                      input logic cgnt, input logic cstall, input logic crv, input logic [DW-1:0] crd,
                      input logic dgnt, input logic drv, input logic [DW-1:0] drd,
                      input logic [AW-1:0] raddr, input logic [DW-1:0] rwd, input logic rwr);
    model_t        s;
    int            win, oth;
    logic          own_req, oth_req;
    logic [AW-1:0] e_addr;
    logic [DW-1:0] e_wd;
    logic          e_wr;
    string         p;
    s = m[id];
    p = (id == 0) ? "a." : "b.";

    chk({p, "cpu_rvalid"}, crv, s.exp_crv);
    chk({p, "dma_rvalid"}, drv, s.exp_drv);
    if (s.exp_crv) chk({p, "cpu_rdata"}, crd, s.exp_rd);
    if (s.exp_drv) chk({p, "dma_rdata"}, drd, s.exp_rd);

    win = 0;
    if (!rst) begin
      if (s.busy == 0) begin
        if (creq && (!dreq || s.last_win == 2)) win = 1;
        else if (dreq)                          win = 2;
      end else begin
        oth     = 3 - s.busy;
        own_req = (s.busy == 1) ? creq : dreq;
        oth_req = (oth == 1) ? creq : dreq;
        if (own_req && (s.streak < max_b || !oth_req)) win = s.busy;
        else if (oth_req)                              win = oth;
      end
    end

    e_addr = '0; e_wd = '0; e_wr = 1'b0;
    if (win == 1) begin e_addr = caddr; e_wd = cwd; e_wr = cwe; end
    if (win == 2) begin e_addr = daddr; e_wd = dwd; e_wr = dwe; end

    chk({p, "cpu_gnt"},   cgnt,   win == 1);
    chk({p, "dma_gnt"},   dgnt,   win == 2);
    chk({p, "cpu_stall"}, cstall, creq && win != 1);
    chk({p, "ram_addr"},  raddr,  e_addr);
    chk({p, "ram_wdata"}, rwd,    e_wd);
    chk({p, "ram_write"}, rwr,    e_wr);

    if (rec_id == id) begin
      hd.push_back(cgnt ? 1 : (dgnt ? 2 : 0));
      hm.push_back(win);
    end

    s.exp_crv = (win == 1) && !cwe;
    s.exp_drv = (win == 2) && !dwe;
    if (win != 0 && !e_wr) s.exp_rd = shadow[id][e_addr];
    if (win != 0 && e_wr)  shadow[id][e_addr] = e_wd;

    if (rst) begin
      s.busy = 0; s.streak = 0; s.last_win = 2;
    end else if (win == 0) begin
      s.busy = 0; s.streak = 0;
    end else begin
      s.streak   = (win == s.busy) ? s.streak + 1 : 1;
      s.busy     = win;
      s.last_win = win;
    end
    m[id] = s;
  endtask

  // Every-cycle comparison of both instances against the model.
  always @(negedge clk) begin
    if (chk_on) begin
      step(0, 4, a_cpu_req, a_cpu_we, a_cpu_addr, a_cpu_wdata,
           a_dma_req, a_dma_we, a_dma_addr, a_dma_wdata,
           a_cpu_gnt, a_cpu_stall, a_cpu_rvalid, a_cpu_rdata,
           a_dma_gnt, a_dma_rvalid, a_dma_rdata,
           a_ram_addr, a_ram_wdata, a_ram_write);
      step(1, 1, b_cpu_req, b_cpu_we, b_cpu_addr, b_cpu_wdata,
           b_dma_req, b_dma_we, b_dma_addr, b_dma_wdata,
           b_cpu_gnt, b_cpu_stall, b_cpu_rvalid, b_cpu_rdata,
           b_dma_gnt, b_dma_rvalid, b_dma_rdata,
           b_ram_addr, b_ram_wdata, b_ram_write);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin : main
    int   k, cyc;
    logic gd, gc;
    int   exp_c [10];

    a_cpu_req = 0; a_cpu_we = 0; a_cpu_addr = '0; a_cpu_wdata = '0;
    a_dma_req = 0; a_dma_we = 0; a_dma_addr = '0; a_dma_wdata = '0;
    b_cpu_req = 0; b_cpu_we = 0; b_cpu_addr = '0; b_cpu_wdata = '0;
    b_dma_req = 0; b_dma_we = 0; b_dma_addr = '0; b_dma_wdata = '0;
    for (int i = 0; i < 2; i++) begin
      for (int j = 0; j < 2048; j++) begin
        mem[i][j]    = '0;
        shadow[i][j] = '0;
      end
      m[i].busy = 0; m[i].streak = 0; m[i].last_win = 2;
      m[i].exp_crv = 1'b0; m[i].exp_drv = 1'b0; m[i].exp_rd = '0;
    end
    mem[0][11'h010] = 16'hBEEF; shadow[0][11'h010] = 16'hBEEF;
    mem[1][11'h010] = 16'hC0C0; shadow[1][11'h010] = 16'hC0C0;
    mem[1][11'h011] = 16'hD0D0; shadow[1][11'h011] = 16'hD0D0;

    rst = 1'b1;
    tick;
    chk_on = 1'b1;
    tick;
    @(negedge clk);
    chk("rst.cpu_rvalid", a_cpu_rvalid, 0);
    chk("rst.ram_write",  a_ram_write,  0);
    tick;

    // Lone CPU read right after reset.
    rst = 1'b0;
    a_cpu_req = 1; a_cpu_we = 0; a_cpu_addr = 11'h010;
    @(negedge clk);
    chk("A.cpu_gnt",  a_cpu_gnt,  1);
    chk("A.ram_addr", a_ram_addr, 11'h010);
    tick;
    a_cpu_req = 0;
    @(negedge clk);
    chk("A.cpu_rvalid", a_cpu_rvalid, 1);
    chk("A.cpu_rdata",  a_cpu_rdata,  16'hBEEF);
    chk("A.dma_rvalid", a_dma_rvalid, 0);
    tick;

    // Tie on the first cycle after reset: CPU first, DMA next.
    rst = 1'b1;
    tick;
    rst = 1'b0;
    a_cpu_req = 1; a_cpu_addr = 11'h010;
    a_dma_req = 1; a_dma_we = 0; a_dma_addr = 11'h011;
    @(negedge clk);
    chk("B.cpu_first", a_cpu_gnt, 1);
    chk("B.dma_waits", a_dma_gnt, 0);
    tick;
    a_cpu_req = 0;
    @(negedge clk);
    chk("B.dma_next", a_dma_gnt, 1);
    tick;
    a_dma_req = 0;
    tick;

    // DMA streams 8 writes; CPU joins at cycle 2 and gets in after 4 DMA grants.
    exp_c = '{2, 2, 2, 2, 1, 2, 2, 2, 2, 0};
    hd.delete(); hm.delete();
    rec_id = 0;
    a_dma_req = 1; a_dma_we = 1; a_dma_addr = 11'h100; a_dma_wdata = 16'hA000;
    k = 0; cyc = 0;
    while (k < 8 && cyc < 40) begin
      if (cyc == 2) begin
        a_cpu_req = 1; a_cpu_we = 1; a_cpu_addr = 11'h030; a_cpu_wdata = 16'h0055;
      end
      @(negedge clk);
      gd = a_dma_gnt; gc = a_cpu_gnt;
      tick;
      if (gc) a_cpu_req = 0;
      if (gd) begin
        k++;
        a_dma_addr  = a_dma_addr + 11'd1;
        a_dma_wdata = a_dma_wdata + 16'd1;
      end
      cyc++;
    end
    a_dma_req = 0; a_dma_we = 0; a_cpu_we = 0;
    tick;
    rec_id = -1;
    chk("C.dma_done", k, 8);
    chk("C.hist_len", hd.size(), 10);
    for (int i = 0; i < 10; i++) begin
      if (i < hd.size()) chk($sformatf("C.grant[%0d]", i), hd[i], exp_c[i]);
      if (i < hm.size()) chk($sformatf("C.model[%0d]", i), hm[i], exp_c[i]);
    end
    for (int i = 0; i < 8; i++)
      chk($sformatf("C.ram[%0h]", 11'h100 + i), mem[0][11'h100 + i], 16'hA000 + i);
    chk("C.ram[030]", mem[0][11'h030], 16'h0055);

    // CPU write then DMA read of the same word.
    a_cpu_req = 1; a_cpu_we = 1; a_cpu_addr = 11'h020; a_cpu_wdata = 16'h1234;
    @(negedge clk);
    chk("D.cpu_gnt",   a_cpu_gnt,   1);
    chk("D.ram_write", a_ram_write, 1);
    tick;
    a_cpu_req = 0; a_cpu_we = 0;
    a_dma_req = 1; a_dma_we = 0; a_dma_addr = 11'h020;
    @(negedge clk);
    chk("D.dma_gnt",    a_dma_gnt,    1);
    chk("D.cpu_rvalid", a_cpu_rvalid, 0);
    tick;
    a_dma_req = 0;
    @(negedge clk);
    chk("D.dma_rvalid",  a_dma_rvalid, 1);
    chk("D.dma_rdata",   a_dma_rdata,  16'h1234);
    chk("D.cpu_rvalid2", a_cpu_rvalid, 0);
    tick;

    // Reset right after a granted CPU read, with a DMA write pending.
    a_cpu_req = 1; a_cpu_we = 0; a_cpu_addr = 11'h010;
    @(negedge clk);
    chk("E.cpu_gnt", a_cpu_gnt, 1);
    tick;
    a_cpu_req = 0; rst = 1'b1;
    a_dma_req = 1; a_dma_we = 1; a_dma_addr = 11'h040; a_dma_wdata = 16'hDEAD;
    @(negedge clk);
    chk("E.rvalid_pending", a_cpu_rvalid, 1);
    chk("E.no_write",       a_ram_write,  0);
    chk("E.no_gnt",         a_dma_gnt,    0);
    tick;
    @(negedge clk);
    chk("E.rvalid_dropped", a_cpu_rvalid, 0);
    chk("E.no_write2",      a_ram_write,  0);
    tick;
    rst = 1'b0; a_dma_req = 0; a_dma_we = 0;
    tick;
    chk("E.ram[040]", mem[0][11'h040], 16'h0000);

    // MAX_BURST=1 instance: both read continuously, strict alternation.
    b_cpu_req = 1; b_cpu_we = 0; b_cpu_addr = 11'h010;
    b_dma_req = 1; b_dma_we = 0; b_dma_addr = 11'h011;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      chk($sformatf("F.cpu_gnt[%0d]", i),   b_cpu_gnt,   (i % 2) == 0);
      chk($sformatf("F.dma_gnt[%0d]", i),   b_dma_gnt,   (i % 2) == 1);
      chk($sformatf("F.cpu_stall[%0d]", i), b_cpu_stall, (i % 2) == 1);
      if (i > 0) begin
        chk($sformatf("F.cpu_rvalid[%0d]", i), b_cpu_rvalid, (i % 2) == 1);
        chk($sformatf("F.dma_rvalid[%0d]", i), b_dma_rvalid, (i % 2) == 0);
        if ((i % 2) == 1) chk($sformatf("F.cpu_rdata[%0d]", i), b_cpu_rdata, 16'hC0C0);
        else              chk($sformatf("F.dma_rdata[%0d]", i), b_dma_rdata, 16'hD0D0);
      end
      tick;
    end
    b_cpu_req = 0; b_dma_req = 0;
    tick;
    tick;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
